// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store (data has priority, fetch is boosted after MAX_WAIT losses).
// Define ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT cycles and report them on err.
module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 10,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    // The abort counter is 4 bits wide, so the limit must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    state_t            state_q,    state_d;
    owner_t            owner_q,    owner_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [DATA_W-1:0] f_rdata_q,  f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              grant_data;
    logic              grant_fetch;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);
    logic [3:0] to_cnt_q, to_cnt_d;
    logic       err_q,    err_d;
`endif

    // Data wins a collision unless fetch has already lost MAX_WAIT times in a row.
    always_comb begin
        grant_data  = d_req && (!f_req || (wait_cnt_q < WAIT_MAX));
        grant_fetch = f_req && !grant_data;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d = S_ACCESS;
                    owner_d = OWN_DATA;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    if (f_req && (wait_cnt_q < WAIT_MAX)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else if (grant_fetch) begin
                    state_d    = S_ACCESS;
                    owner_d    = OWN_FETCH;
                    addr_d     = f_addr;
                    we_d       = 1'b0;
                    wdata_d    = '0;
                    wait_cnt_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                // Counts ACCESS cycles including the current one.
                to_cnt_d = 4'd1;
`endif
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_FETCH) begin
                        f_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_DATA && !we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LIMIT) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        mem_en    = (state_q == S_ACCESS);
        mem_we    = (state_q == S_ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        f_gnt     = (state_q == S_ACCESS || state_q == S_DONE) && (owner_q == OWN_FETCH);
        d_gnt     = (state_q == S_ACCESS || state_q == S_DONE) && (owner_q == OWN_DATA);
        f_done    = (state_q == S_DONE) && (owner_q == OWN_FETCH);
        d_done    = (state_q == S_DONE) && (owner_q == OWN_DATA);
        f_rdata   = f_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build, parameters 8/10/4/15).
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_gnt;
    logic [9:0] f_rdata;
    logic       f_done;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [9:0] d_wdata;
    logic       d_gnt;
    logic [9:0] d_rdata;
    logic       d_done;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [9:0] mem_wdata;
    logic [9:0] mem_rdata;
    logic       mem_ready;
    logic       err;

    int n_cmp;
    int n_bad;

    mem_port_arbiter #(
        .ADDR_W  (8),
        .DATA_W  (10),
        .MAX_WAIT(4),
        .TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rdata  (f_rdata),
        .f_done   (f_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        f_req     = 1'b1;
        f_addr    = 8'h77;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 8'h66;
        d_wdata   = 10'h3FF;
        mem_ready = 1'b1;
        mem_rdata = 10'h155;
        tick();
        tick();
        n_cmp++;
        if ({f_gnt, d_gnt, f_done, d_done, mem_en, mem_we, err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 0000000", {f_gnt, d_gnt, f_done, d_done, mem_en, mem_we, err});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 38'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, f_rdata, d_rdata});
        end
        f_req     = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        f_req     = 1'b1;
        f_addr    = 8'h05;
        mem_ready = 1'b1;
        mem_rdata = 10'h2A3;
        n_cmp++;
        if (mem_en !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_idle_en got %b want 0", mem_en);
        end
        tick();
        n_cmp++;
        if ({mem_en, mem_we, f_gnt, d_gnt, f_done} !== 5'b10100) begin
            n_bad++;
            $display("FAIL fetch_access got %b want 10100", {mem_en, mem_we, f_gnt, d_gnt, f_done});
        end
        n_cmp++;
        if (mem_addr !== 8'h05) begin
            n_bad++;
            $display("FAIL fetch_addr got %h want 05", mem_addr);
        end
        tick();
        n_cmp++;
        if ({f_done, d_done, mem_en, f_gnt} !== 4'b1001) begin
            n_bad++;
            $display("FAIL fetch_done got %b want 1001", {f_done, d_done, mem_en, f_gnt});
        end
        n_cmp++;
        if (f_rdata !== 10'h2A3) begin
            n_bad++;
            $display("FAIL fetch_rdata got %h want 2a3", f_rdata);
        end
        f_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        n_cmp++;
        if ({f_done, f_gnt, mem_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL fetch_after got %b want 000", {f_done, f_gnt, mem_en});
        end
    endtask

    task automatic test_store();
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 8'h10;
        d_wdata   = 10'h0FF;
        mem_ready = 1'b1;
        mem_rdata = 10'h155;
        tick();
        n_cmp++;
        if ({mem_en, mem_we, d_gnt, f_gnt} !== 4'b1110) begin
            n_bad++;
            $display("FAIL store_access got %b want 1110", {mem_en, mem_we, d_gnt, f_gnt});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {8'h10, 10'h0FF}) begin
            n_bad++;
            $display("FAIL store_addr_data got %h/%h want 10/0ff", mem_addr, mem_wdata);
        end
        tick();
        n_cmp++;
        if ({d_done, mem_en, mem_we, d_gnt} !== 4'b1001) begin
            n_bad++;
            $display("FAIL store_done got %b want 1001", {d_done, mem_en, mem_we, d_gnt});
        end
        n_cmp++;
        if (d_rdata !== 10'h000) begin
            n_bad++;
            $display("FAIL store_rdata_kept got %h want 000", d_rdata);
        end
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        tick();
        n_cmp++;
        if (d_done !== 1'b0) begin
            n_bad++;
            $display("FAIL store_done_width got %b want 0", d_done);
        end
    endtask

    task automatic test_wait_states();
        int en_cycles;
        int done_pulses;
        en_cycles   = 0;
        done_pulses = 0;
        // Stray mem_ready while idle must do nothing.
        mem_ready = 1'b1;
        mem_rdata = 10'h0AA;
        tick();
        n_cmp++;
        if ({mem_en, d_done, f_done} !== 3'b000 || d_rdata !== 10'h000) begin
            n_bad++;
            $display("FAIL idle_ready got %b/%h want 000/000", {mem_en, d_done, f_done}, d_rdata);
        end
        mem_ready = 1'b0;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 8'h33;
        tick();
        // Request changes after the sample are ignored, and dropping it does not cancel.
        d_req  = 1'b0;
        d_addr = 8'h44;
        d_we   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (mem_en === 1'b1 && mem_addr === 8'h33 && mem_we === 1'b0) en_cycles++;
            if (d_done === 1'b1) done_pulses++;
            if (k == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 10'h3C7;
            end
            tick();
        end
        mem_ready = 1'b0;
        n_cmp++;
        if (en_cycles !== 4) begin
            n_bad++;
            $display("FAIL wait_en_cycles got %0d want 4", en_cycles);
        end
        n_cmp++;
        if ({d_done, mem_en} !== 2'b10 || d_rdata !== 10'h3C7) begin
            n_bad++;
            $display("FAIL wait_done got %b/%h want 10/3c7", {d_done, mem_en}, d_rdata);
        end
        done_pulses++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (d_done === 1'b1 || mem_en === 1'b1) done_pulses += 10;
        end
        n_cmp++;
        if (done_pulses !== 1) begin
            n_bad++;
            $display("FAIL wait_single_done got %0d want 1", done_pulses);
        end
        d_we = 1'b0;
    endtask

    task automatic test_collision();
        logic [9:0] exp_seq;
        logic [9:0] got_seq;
        int         n_grants;
        int         both_gnt;
        exp_seq  = 10'b1111011110;
        got_seq  = '0;
        n_grants = 0;
        both_gnt = 0;
        f_req     = 1'b1;
        f_addr    = 8'h20;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 8'h30;
        mem_ready = 1'b1;
        mem_rdata = 10'h111;
        for (int c = 0; c < 60 && n_grants < 10; c++) begin
            tick();
            if (f_gnt === 1'b1 && d_gnt === 1'b1) both_gnt++;
            if (mem_en === 1'b1) begin
                got_seq[9 - n_grants] = (d_gnt === 1'b1 && mem_addr === 8'h30);
                n_grants++;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        n_cmp++;
        if (n_grants !== 10) begin
            n_bad++;
            $display("FAIL collision_budget got %0d grants want 10", n_grants);
        end
        n_cmp++;
        if (got_seq !== exp_seq) begin
            n_bad++;
            $display("FAIL collision_order got %b want %b (1=data)", got_seq, exp_seq);
        end
        n_cmp++;
        if (both_gnt !== 0) begin
            n_bad++;
            $display("FAIL collision_both_gnt got %0d want 0", both_gnt);
        end
        n_cmp++;
        if ({mem_en, f_gnt, d_gnt} !== 3'b000 || f_rdata !== 10'h111) begin
            n_bad++;
            $display("FAIL collision_end got %b/%h want 000/111", {mem_en, f_gnt, d_gnt}, f_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int dones;
        dones     = 0;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 8'h5A;
        d_wdata   = 10'h2B4;
        mem_ready = 1'b0;
        tick();
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_mid_pre got %b want 11", {mem_en, mem_we});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, d_gnt} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid_async got %b want 000", {mem_en, mem_we, d_gnt});
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (d_done === 1'b1 || f_done === 1'b1 || mem_en === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0 || f_rdata !== 10'h000) begin
            n_bad++;
            $display("FAIL rst_mid_after got %0d/%h want 0/000", dones, f_rdata);
        end
        f_req     = 1'b1;
        f_addr    = 8'h81;
        mem_ready = 1'b1;
        mem_rdata = 10'h0AB;
        tick();
        tick();
        n_cmp++;
        if ({f_done, f_rdata} !== {1'b1, 10'h0AB}) begin
            n_bad++;
            $display("FAIL rst_mid_recover got %b/%h want 1/0ab", f_done, f_rdata);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_tied got %b want 0", err);
        end
        f_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fetch();
        test_store();
        test_wait_states();
        test_collision();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
